bicubic_result_reader: RTL and testbench

- Read-back engine for the ResultSRAM image written by the bicubic upscaler.
- After a START pulse (normally the upscaler's DONE), it reads the TW x TH result raster in address order.
- Streams the pixels out over a valid/ready interface with (x, y) tags and a last flag.
- Accumulates a 16-bit checksum. Used for result dump, display streaming and self-check.

---
 rtl/bicubic_result_reader.sv | 182 ++++++++++++++++++
 tb/tb_bicubic_result_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_result_reader.sv
// Read-back engine for the bicubic upscaler's ResultSRAM.
// On an accepted START it reads the TW x TH raster in address order, buffers
// the returned bytes in a small FIFO, streams them out over valid/ready with
// (x, y) tags and a last flag, and accumulates a 16-bit checksum.
module bicubic_result_reader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 14
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [5:0]    TW,
  input  logic [5:0]    TH,
  input  logic [7:0]    SRAM_Q,
  output logic          SRAM_CEN,
  output logic          SRAM_WEN,
  output logic [AW-1:0] SRAM_A,
  output logic          PIX_VALID,
  input  logic          PIX_READY,
  output logic [7:0]    PIX_DATA,
  output logic [5:0]    PIX_X,
  output logic [5:0]    PIX_Y,
  output logic          PIX_LAST,
  output logic          BUSY,
  output logic          RD_DONE,
  output logic [15:0]   CHECKSUM
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [5:0]        tw_r;
  logic [11:0]       total_r;
  logic [11:0]       total_in;
  logic [11:0]       issued_cnt;
  logic [11:0]       out_cnt;
  logic [RD_LAT-1:0] dv;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     inflight;
  logic [CW:0]       occ;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept   = (state == S_IDLE) && START;
  assign total_in = 12'(TW) * 12'(TH);

  // Count reads whose data has not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(dv[i]);
    end
  end

  // Reserving FIFO space for in-flight reads is what keeps the FIFO from overflowing.
  assign occ   = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign issue = (state == S_READ) && (issued_cnt < total_r) &&
                 (occ < (CW+1)'(FIFO_DEPTH));
  assign push  = dv[RD_LAT-1];
  assign pop   = PIX_VALID && PIX_READY;

  assign SRAM_CEN  = ~issue;
  assign SRAM_WEN  = 1'b1;
  assign SRAM_A    = issue ? AW'(issued_cnt) : '0;
  assign PIX_VALID = (fifo_cnt != '0);
  assign PIX_DATA  = fifo_mem[rd_ptr];
  assign PIX_LAST  = PIX_VALID && (out_cnt == total_r - 12'd1);
  assign BUSY      = (state != S_IDLE);
  assign RD_DONE   = (state == S_FINISH);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = (total_in == '0) ? S_FINISH : S_READ;
      S_READ:   if (issue && (issued_cnt == total_r - 12'd1)) state_nxt = S_DRAIN;
      S_DRAIN:  if (pop && PIX_LAST) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Frame geometry latch and read address counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tw_r       <= '0;
      total_r    <= '0;
      issued_cnt <= '0;
    end else if (accept) begin
      tw_r       <= TW;
      total_r    <= total_in;
      issued_cnt <= '0;
    end else if (issue) begin
      issued_cnt <= issued_cnt + 12'd1;
    end
  end

  // Delayed-valid pipe marking the cycle each read's data is on SRAM_Q.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dv <= '0;
    end else begin
      dv[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        dv[i] <= dv[i-1];
      end
    end
  end

  // Output FIFO; storage is cleared on reset so PIX_DATA resets to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= SRAM_Q;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Output tags, output index and checksum advance on each handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PIX_X    <= '0;
      PIX_Y    <= '0;
      out_cnt  <= '0;
      CHECKSUM <= '0;
    end else if (accept) begin
      PIX_X    <= '0;
      PIX_Y    <= '0;
      out_cnt  <= '0;
      CHECKSUM <= '0;
    end else if (pop) begin
      out_cnt  <= out_cnt + 12'd1;
      CHECKSUM <= CHECKSUM + {8'h00, PIX_DATA};
      if (PIX_X == tw_r - 6'd1) begin
        PIX_X <= '0;
        PIX_Y <= PIX_Y + 6'd1;
      end else begin
        PIX_X <= PIX_X + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_result_reader.sv
// Directed bench for bicubic_result_reader: one RD_LAT=1 instance for the
// small frames, stall, zero-size, ignored-START and reset cases, and one
// RD_LAT=2 instance for the full 63x63 frame.
module tb_bicubic_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [5:0]  tw, th, tw2, th2;
  logic        ready, ready2;
  logic        mon_clr, mon2_clr;

  logic [7:0]  q1, q2, q2a;
  logic        cen1, wen1, v1, l1, busy1, done1;
  logic [13:0] a1;
  logic [7:0]  d1;
  logic [5:0]  x1, y1;
  logic [15:0] cs1;
  logic        cen2, wen2, v2, l2, busy2, done2;
  logic [13:0] a2;
  logic [7:0]  d2;
  logic [5:0]  x2, y2;
  logic [15:0] cs2;

  logic [7:0]  mem1 [64];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  bicubic_result_reader #(.RD_LAT(1), .FIFO_DEPTH(4), .AW(14)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .TW(tw), .TH(th), .SRAM_Q(q1),
    .SRAM_CEN(cen1), .SRAM_WEN(wen1), .SRAM_A(a1), .PIX_VALID(v1),
    .PIX_READY(ready), .PIX_DATA(d1), .PIX_X(x1), .PIX_Y(y1), .PIX_LAST(l1),
    .BUSY(busy1), .RD_DONE(done1), .CHECKSUM(cs1)
  );

  bicubic_result_reader #(.RD_LAT(2), .FIFO_DEPTH(4), .AW(14)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start2), .TW(tw2), .TH(th2), .SRAM_Q(q2),
    .SRAM_CEN(cen2), .SRAM_WEN(wen2), .SRAM_A(a2), .PIX_VALID(v2),
    .PIX_READY(ready2), .PIX_DATA(d2), .PIX_X(x2), .PIX_Y(y2), .PIX_LAST(l2),
    .BUSY(busy2), .RD_DONE(done2), .CHECKSUM(cs2)
  );

  // SRAM models: data appears RD_LAT cycles after the CEN-low cycle, zero otherwise.
  always @(posedge clk) q1 <= !cen1 ? mem1[a1[5:0]] : 8'h00;
  always @(posedge clk) begin
    q2a <= !cen2 ? 8'hFF : 8'h00;
    q2  <= q2a;
  end

  // Monitor for the RD_LAT=1 instance.
  int n_rd, n_pix, n_done, n_last, n_valid, addr_err, ovf, stall_err, max_out;
  int start_cyc, fv_cyc, done_cyc, last_cyc;
  logic       stalled, sl;
  logic [7:0] sd;
  logic [5:0] sx, sy;
  logic [7:0] pd [64];
  logic [5:0] px [64];
  logic [5:0] py [64];
  logic       pl [64];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      n_rd <= 0; n_pix <= 0; n_done <= 0; n_last <= 0; n_valid <= 0;
      addr_err <= 0; ovf <= 0; stall_err <= 0; max_out <= 0;
      start_cyc <= cyc; fv_cyc <= -1; done_cyc <= -1; last_cyc <= -1;
      stalled <= 1'b0;
    end else begin
      if (!cen1) begin
        if (a1 != 14'(n_rd)) addr_err <= addr_err + 1;
        if (n_rd - n_pix >= 4) ovf <= ovf + 1;
      end
      if (v1) begin
        n_valid <= n_valid + 1;
        if (fv_cyc < 0) fv_cyc <= cyc;
        if (stalled && (d1 != sd || x1 != sx || y1 != sy || l1 != sl))
          stall_err <= stall_err + 1;
      end
      stalled <= v1 && !ready;
      sd <= d1; sx <= x1; sy <= y1; sl <= l1;
      if (v1 && ready) begin
        if (n_pix < 64) begin
          pd[n_pix] <= d1; px[n_pix] <= x1; py[n_pix] <= y1; pl[n_pix] <= l1;
        end
        if (l1) begin
          n_last   <= n_last + 1;
          last_cyc <= cyc;
        end
      end
      n_rd  <= n_rd + (!cen1 ? 1 : 0);
      n_pix <= n_pix + ((v1 && ready) ? 1 : 0);
      if ((n_rd + (!cen1 ? 1 : 0)) - (n_pix + ((v1 && ready) ? 1 : 0)) > max_out)
        max_out <= (n_rd + (!cen1 ? 1 : 0)) - (n_pix + ((v1 && ready) ? 1 : 0));
      if (done1) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
    end
  end

  // Monitor for the RD_LAT=2 instance.
  int n2_rd, n2_pix, n2_done, n2_last, n2_bad, n2_aerr;
  int s2_cyc, fv2_cyc, fhs2_cyc, lhs2_cyc, done2_cyc;
  logic [5:0] lx2, ly2;

  always @(negedge clk) begin
    if (mon2_clr) begin
      n2_rd <= 0; n2_pix <= 0; n2_done <= 0; n2_last <= 0; n2_bad <= 0; n2_aerr <= 0;
      s2_cyc <= cyc; fv2_cyc <= -1; fhs2_cyc <= -1; lhs2_cyc <= -1; done2_cyc <= -1;
      lx2 <= '0; ly2 <= '0;
    end else begin
      if (!cen2) begin
        if (a2 != 14'(n2_rd)) n2_aerr <= n2_aerr + 1;
        n2_rd <= n2_rd + 1;
      end
      if (v2 && fv2_cyc < 0) fv2_cyc <= cyc;
      if (v2 && ready2) begin
        n2_pix <= n2_pix + 1;
        if (n2_pix == 0) fhs2_cyc <= cyc;
        if (d2 !== 8'hFF) n2_bad <= n2_bad + 1;
        if (l2) begin
          n2_last <= n2_last + 1; lhs2_cyc <= cyc; lx2 <= x2; ly2 <= y2;
        end
      end
      if (done2) begin
        n2_done <= n2_done + 1; done2_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(input int limit);
    int i;
    i = 0;
    while (n_done == 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    #1;
  endtask

  task automatic wait_done2(input int limit);
    int i;
    i = 0;
    while (n2_done == 0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; tw = '0; th = '0; tw2 = '0; th2 = '0;
    ready = 1'b1; ready2 = 1'b1; mon_clr = 1'b0; mon2_clr = 1'b0;
    for (int i = 0; i < 64; i++) mem1[i] = 8'((i + 1) * 10);
    repeat (3) tick();

    // Reset values
    chk("rst_cen", cen1, 1); chk("rst_wen", wen1, 1); chk("rst_a", a1, 0);
    chk("rst_valid", v1, 0); chk("rst_data", d1, 0); chk("rst_x", x1, 0);
    chk("rst_y", y1, 0); chk("rst_last", l1, 0); chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0); chk("rst_cs", cs1, 0);
    chk("rst2_cen", cen2, 1); chk("rst2_valid", v2, 0); chk("rst2_busy", busy2, 0);
    rst = 1'b0;
    tick();

    // 2x2 frame, READY high
    start = 1'b1; tw = 6'd2; th = 6'd2; mon_clr = 1'b1;
    tick(); start = 1'b0; mon_clr = 1'b0;
    chk("t1_c1_cen", cen1, 0); chk("t1_c1_a", a1, 0); chk("t1_c1_busy", busy1, 1);
    chk("t1_c1_valid", v1, 0);
    tick();
    chk("t1_c2_a", a1, 1); chk("t1_c2_valid", v1, 0);
    tick();
    chk("t1_c3_a", a1, 2); chk("t1_c3_valid", v1, 1); chk("t1_c3_data", d1, 10);
    wait_done1(100);
    chk("t1_ndone", n_done, 1); chk("t1_nrd", n_rd, 4); chk("t1_aerr", addr_err, 0);
    chk("t1_npix", n_pix, 4);
    chk("t1_d0", pd[0], 10); chk("t1_d1", pd[1], 20); chk("t1_d2", pd[2], 30); chk("t1_d3", pd[3], 40);
    chk("t1_x1", px[1], 1); chk("t1_y1", py[1], 0); chk("t1_x2", px[2], 0); chk("t1_y2", py[2], 1);
    chk("t1_x3", px[3], 1); chk("t1_y3", py[3], 1);
    chk("t1_last3", pl[3], 1); chk("t1_nlast", n_last, 1);
    chk("t1_fv_lat", fv_cyc - start_cyc, 3);
    chk("t1_done_after_last", done_cyc - last_cyc, 1);
    chk("t1_done_lat", done_cyc - start_cyc, 7);
    chk("t1_cs", cs1, 100); chk("t1_busy_after", busy1, 0); chk("t1_rddone_after", done1, 0);

    // 8x1 frame with READY low in cycles 3..9
    start = 1'b1; tw = 6'd8; th = 6'd1; mon_clr = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      start = 1'b0; mon_clr = 1'b0;
      ready = !(i >= 3 && i <= 9);
    end
    wait_done1(100);
    chk("t2_ndone", n_done, 1); chk("t2_nrd", n_rd, 8); chk("t2_npix", n_pix, 8);
    chk("t2_aerr", addr_err, 0); chk("t2_ovf", ovf, 0); chk("t2_stall", stall_err, 0);
    chk("t2_maxout", max_out, 4); chk("t2_nlast", n_last, 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_d%0d", k), pd[k], (k + 1) * 10);
      chk($sformatf("t2_x%0d", k), px[k], k);
    end
    chk("t2_cs", cs1, 360);

    // Zero-width frame
    start = 1'b1; tw = 6'd0; th = 6'd5; mon_clr = 1'b1;
    tick(); start = 1'b0; mon_clr = 1'b0;
    chk("t3_c1_done", done1, 1); chk("t3_c1_busy", busy1, 1); chk("t3_c1_cen", cen1, 1);
    tick();
    chk("t3_c2_done", done1, 0); chk("t3_c2_busy", busy1, 0); chk("t3_cs", cs1, 0);
    repeat (3) tick();
    chk("t3_nrd", n_rd, 0); chk("t3_nvalid", n_valid, 0); chk("t3_ndone", n_done, 1);
    chk("t3_done_lat", done_cyc - start_cyc, 1);

    // 4x2 frame with a second START mid-frame
    start = 1'b1; tw = 6'd4; th = 6'd2; mon_clr = 1'b1;
    tick(); start = 1'b0; mon_clr = 1'b0;
    repeat (3) tick();
    start = 1'b1; tw = 6'd3; th = 6'd1;
    tick(); start = 1'b0; tw = 6'd0;
    wait_done1(100);
    chk("t4_ndone", n_done, 1); chk("t4_nrd", n_rd, 8); chk("t4_npix", n_pix, 8);
    chk("t4_aerr", addr_err, 0);
    chk("t4_x3", px[3], 3); chk("t4_y3", py[3], 0); chk("t4_x5", px[5], 1); chk("t4_y5", py[5], 1);
    chk("t4_last7", pl[7], 1); chk("t4_nlast", n_last, 1); chk("t4_cs", cs1, 360);

    // 4x4 frame aborted by reset after 5 pixels
    start = 1'b1; tw = 6'd4; th = 6'd4; mon_clr = 1'b1;
    tick(); start = 1'b0; mon_clr = 1'b0;
    repeat (7) tick();
    chk("t5_npix_pre", n_pix, 5); chk("t5_cs_pre", cs1, 150); chk("t5_busy_pre", busy1, 1);
    rst = 1'b1;
    #1;
    chk("t5_cen", cen1, 1); chk("t5_a", a1, 0); chk("t5_valid", v1, 0); chk("t5_data", d1, 0);
    chk("t5_x", x1, 0); chk("t5_y", y1, 0); chk("t5_last", l1, 0); chk("t5_busy", busy1, 0);
    chk("t5_done", done1, 0); chk("t5_cs", cs1, 0);
    tick(); rst = 1'b0;
    chk("t5_c9_valid", v1, 0);
    tick();
    chk("t5_ndone_abort", n_done, 0); chk("t5_c10_valid", v1, 0);
    start = 1'b1; tw = 6'd2; th = 6'd2; mon_clr = 1'b1;
    tick(); start = 1'b0; mon_clr = 1'b0;
    chk("t5r_a0", a1, 0); chk("t5r_cen", cen1, 0);
    wait_done1(100);
    chk("t5r_ndone", n_done, 1); chk("t5r_nrd", n_rd, 4); chk("t5r_npix", n_pix, 4);
    chk("t5r_aerr", addr_err, 0); chk("t5r_d0", pd[0], 10); chk("t5r_d3", pd[3], 40);
    chk("t5r_fv_lat", fv_cyc - start_cyc, 3); chk("t5r_cs", cs1, 100);

    // 63x63 frame of 255s on the RD_LAT=2 instance
    start2 = 1'b1; tw2 = 6'd63; th2 = 6'd63; mon2_clr = 1'b1;
    tick(); start2 = 1'b0; mon2_clr = 1'b0;
    wait_done2(5000);
    chk("t6_ndone", n2_done, 1); chk("t6_nrd", n2_rd, 3969); chk("t6_npix", n2_pix, 3969);
    chk("t6_aerr", n2_aerr, 0); chk("t6_bad", n2_bad, 0); chk("t6_nlast", n2_last, 1);
    chk("t6_lx", lx2, 62); chk("t6_ly", ly2, 62);
    chk("t6_span", lhs2_cyc - fhs2_cyc, 3968);
    chk("t6_fv_lat", fv2_cyc - s2_cyc, 4);
    chk("t6_done_after_last", done2_cyc - lhs2_cyc, 1);
    chk("t6_cs", cs2, (3969 * 255) % 65536);
    chk("t6_busy_after", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
